// File: rtl/ofm_reader.sv
// Output feature-map drain: reads every neuron in address order and streams it out
// through a credit-gated FIFO. Optional ReLU on the stream data via OFM_RELU_EN.
module ofm_reader #(
  parameter int OUT_SIZE    = 2,
  parameter int OUT_CHANNEL = 1,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 1,
  parameter int FIFO_DEPTH  = RD_LAT + 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_ena,
  output logic [7:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [1:0]        m_chan_idx,
  output logic [3:0]        m_pix_idx
);
  localparam int PIX_N = OUT_SIZE * OUT_SIZE;
  localparam int N     = PIX_N * OUT_CHANNEL;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam int EW    = DATA_W + 7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [8:0]        issue_cnt;
  logic [3:0]        pix_cnt;
  logic [1:0]        chan_cnt;
  logic [RD_LAT:0]   vld_pipe;
  logic [6:0]        meta_pipe [RD_LAT+1];
  logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_count, inflight, committed;
  logic              issue, push, pop, credit_ok, last_issue;
  logic [DATA_W-1:0] push_data;
  logic [EW-1:0]     head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef OFM_RELU_EN
  assign push_data = rd_data[DATA_W-1] ? '0 : rd_data;
`else
  assign push_data = rd_data;
`endif

  // Credits cover FIFO contents plus every read still in the latency pipe;
  // this cycle's pop frees a slot so full-rate streaming has no bubbles.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + CW'(vld_pipe[i]);
    m_valid    = (fifo_count != '0);
    pop        = m_valid && m_ready;
    committed  = fifo_count + inflight - CW'(pop);
    credit_ok  = committed < CW'(FIFO_DEPTH);
    issue      = credit_ok && ((state == S_IDLE && start) || state == S_READ);
    last_issue = (issue_cnt == 9'(N - 1));
    push       = vld_pipe[RD_LAT];
    head       = fifo_mem[rd_ptr];
  end

  assign rd_ena     = vld_pipe[0];
  assign busy       = (state == S_READ) || (state == S_DRAIN);
  assign done       = (state == S_DONE);
  assign m_data     = m_valid ? head[DATA_W-1:0] : '0;
  assign m_pix_idx  = m_valid ? head[DATA_W+3:DATA_W] : '0;
  assign m_chan_idx = m_valid ? head[DATA_W+5:DATA_W+4] : '0;
  assign m_last     = m_valid && head[EW-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      issue_cnt  <= '0;
      pix_cnt    <= '0;
      chan_cnt   <= '0;
      rd_addr    <= '0;
      vld_pipe   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      vld_pipe[0] <= issue;
      for (int i = 1; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (issue) begin
        rd_addr   <= issue_cnt[7:0];
        issue_cnt <= issue_cnt + 1'b1;
        if (pix_cnt == 4'(PIX_N - 1)) begin
          pix_cnt  <= '0;
          chan_cnt <= chan_cnt + 1'b1;
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      case (state)
        S_IDLE:  if (issue) state <= last_issue ? S_DRAIN : S_READ;
        S_READ:  if (issue && last_issue) state <= S_DRAIN;
        S_DRAIN: if (pop && head[EW-1]) state <= S_DONE;
        default: begin
          state     <= S_IDLE;
          issue_cnt <= '0;
          pix_cnt   <= '0;
          chan_cnt  <= '0;
        end
      endcase
    end
  end

  // Data path carries no reset; outputs are masked by m_valid instead.
  always_ff @(posedge clock) begin
    if (issue) meta_pipe[0] <= {last_issue, chan_cnt, pix_cnt};
    for (int i = 1; i <= RD_LAT; i++) meta_pipe[i] <= meta_pipe[i-1];
    if (push) fifo_mem[wr_ptr] <= {meta_pipe[RD_LAT], push_data};
  end
endmodule

// File: tb/tb_ofm_reader.sv
// Randomized self-checking bench for ofm_reader: a 1-channel and a 4-channel instance
// checked against an address-order stream model.
module tb_ofm_reader;
  localparam int DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          start = 1'b0, busy, done, rd_ena, m_valid, m_ready = 1'b1, m_last;
  logic [7:0]    rd_addr;
  logic [DW-1:0] rd_data = '0, m_data;
  logic [1:0]    m_chan_idx;
  logic [3:0]    m_pix_idx;

  logic          start_b = 1'b0, busy_b, done_b, rd_ena_b, m_valid_b, m_ready_b = 1'b1, m_last_b;
  logic [7:0]    rd_addr_b;
  logic [DW-1:0] rd_data_b = '0, m_data_b;
  logic [1:0]    m_chan_idx_b;
  logic [3:0]    m_pix_idx_b;

  logic [DW-1:0] mem [256];
  int checks = 0, failures = 0;

  ofm_reader u_dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .rd_ena(rd_ena), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_chan_idx(m_chan_idx), .m_pix_idx(m_pix_idx));

  ofm_reader #(.OUT_CHANNEL(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_ena(rd_ena_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b),
    .m_chan_idx(m_chan_idx_b), .m_pix_idx(m_pix_idx_b));

  // One-cycle-latency buffer; garbage on idle cycles exposes mistimed captures.
  always @(posedge clock) begin
    rd_data   <= rd_ena   ? mem[rd_addr]   : DW'($urandom);
    rd_data_b <= rd_ena_b ? mem[rd_addr_b] : DW'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_data(input int a);
`ifdef OFM_RELU_EN
    return mem[a][DW-1] ? '0 : mem[a];
`else
    return mem[a];
`endif
  endfunction

  // Word i of the drain: {last, chan, pix, data}, 4 pixels per channel.
  function automatic logic [14:0] exp_word(input int i, input int n);
    logic [1:0] c;
    logic [3:0] p;
    c = 2'(i / 4);
    p = 4'(i % 4);
    return {(i == n - 1), c, p, ref_data(i)};
  endfunction

  int exp_idx_a, exp_addr_a, issued_a, hs_a;
  int exp_idx_b, exp_addr_b, issued_b, hs_b;
  bit hold_a, hold_b;
  logic [14:0] hold_w_a, hold_w_b;

  always @(negedge clock) begin
    if (reset) begin
      hold_a = 0;
      hold_b = 0;
    end else begin
      if (hold_a) chk("a_stable", 32'({m_valid, m_last, m_chan_idx, m_pix_idx, m_data}), 32'({1'b1, hold_w_a}));
      if (rd_ena) begin
        chk("a_rd_addr", 32'(rd_addr), 32'(exp_addr_a));
        exp_addr_a++; issued_a++;
        chk("a_outstanding_le3", 32'(issued_a - hs_a <= 3), 32'd1);
      end
      if (m_valid && m_ready) begin
        chk("a_word", 32'({m_last, m_chan_idx, m_pix_idx, m_data}), 32'(exp_word(exp_idx_a, 4)));
        exp_idx_a++; hs_a++;
      end
      hold_a = m_valid && !m_ready;
      hold_w_a = {m_last, m_chan_idx, m_pix_idx, m_data};

      if (hold_b) chk("b_stable", 32'({m_valid_b, m_last_b, m_chan_idx_b, m_pix_idx_b, m_data_b}), 32'({1'b1, hold_w_b}));
      if (rd_ena_b) begin
        chk("b_rd_addr", 32'(rd_addr_b), 32'(exp_addr_b));
        exp_addr_b++; issued_b++;
        chk("b_outstanding_le3", 32'(issued_b - hs_b <= 3), 32'd1);
      end
      if (m_valid_b && m_ready_b) begin
        chk("b_word", 32'({m_last_b, m_chan_idx_b, m_pix_idx_b, m_data_b}), 32'(exp_word(exp_idx_b, 16)));
        exp_idx_b++; hs_b++;
      end
      hold_b = m_valid_b && !m_ready_b;
      hold_w_b = {m_last_b, m_chan_idx_b, m_pix_idx_b, m_data_b};
    end
  end

  // Advance into the next cycle; start pulses last exactly one cycle.
  task automatic step();
    @(posedge clock);
    #1;
    start = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic start_a();
    exp_idx_a = 0; exp_addr_a = 0; issued_a = 0; hs_a = 0;
    start = 1'b1;
  endtask

  task automatic start_b4();
    exp_idx_b = 0; exp_addr_b = 0; issued_b = 0; hs_b = 0;
    start_b = 1'b1;
  endtask

  task automatic wait_done(input bit b, input bit rnd, input string tag, input int n);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      step();
      if (b) m_ready_b = rnd ? 1'($urandom) : 1'b1;
      else   m_ready   = rnd ? 1'($urandom) : 1'b1;
      @(negedge clock);
      if (b ? done_b : done) begin
        seen = 1;
        chk({tag, "_busy_at_done"}, 32'(b ? busy_b : busy), 32'd0);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    step();
    @(negedge clock);
    chk({tag, "_done_pulse"}, 32'(b ? done_b : done), 32'd0);
    chk({tag, "_word_count"}, 32'(b ? hs_b : hs_a), 32'(n));
  endtask

  function automatic logic [31:0] outs_a();
    return 32'({busy, done, rd_ena, rd_addr, m_valid, m_data, m_last, m_chan_idx, m_pix_idx});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] st;
    for (int i = 0; i < 256; i++) mem[i] = DW'(i + 10);

    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clock);
      chk("reset_outs_a", outs_a(), 32'd0);
      chk("reset_outs_b", 32'({busy_b, done_b, rd_ena_b, m_valid_b, m_last_b}), 32'd0);
    end
    step();
    reset = 1'b0;

    // Test 1: full-rate timing
    step(); start_a();
    for (int t = 1; t <= 8; t++) begin
      step();
      @(negedge clock);
      st = {5{1'b0}};
      st[4] = (t >= 1 && t <= 6);
      st[3] = (t == 7);
      st[2] = (t <= 4);
      st[1] = (t >= 3 && t <= 6);
      st[0] = (t == 6);
      chk("t1_ctrl", 32'({busy, done, rd_ena, m_valid, m_last}), 32'(st));
      if (t >= 3 && t <= 6) chk("t1_data", 32'(m_data), 32'(t + 7));
    end

    // Test 2: backpressure cycles 3..10
    step(); start_a();
    for (int t = 1; t <= 10; t++) begin
      step();
      m_ready = !(t >= 3);
      @(negedge clock);
      if (t >= 4) chk("t2_no_issue", 32'(rd_ena), 32'd0);
      if (t >= 3) chk("t2_held", 32'({m_valid, m_data}), 32'({1'b1, 8'd10}));
    end
    chk("t2_issued", 32'(issued_a), 32'd3);
    wait_done(0, 0, "t2", 4);

    // Test 4: reset the cycle after word 1 handshakes
    step(); start_a();
    for (int t = 1; t <= 5; t++) begin
      step();
      m_ready = 1'b1;
      if (t == 5) reset = 1'b1;
      @(negedge clock);
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("t4_outs_zero", outs_a(), 32'd0);
    for (int t = 0; t < 3; t++) begin
      step();
      @(negedge clock);
      chk("t4_idle_after_reset", 32'({busy, rd_ena, m_valid}), 32'd0);
    end
    step(); start_a();
    wait_done(0, 0, "t4", 4);

    // Test 5: start while busy and during DONE is ignored
    step(); start_a();
    for (int t = 1; t <= 11; t++) begin
      step();
      m_ready = 1'b1;
      if (t == 2 || t == 7) start = 1'b1;
      @(negedge clock);
      if (t == 7) chk("t5_done", 32'(done), 32'd1);
      if (t >= 8) chk("t5_quiet", 32'({busy, done, rd_ena, m_valid}), 32'd0);
    end
    chk("t5_issued", 32'(issued_a), 32'd4);

    // Test 6: sign handling
    mem[0] = 8'hF6; mem[1] = 8'h05;
    step(); start_a();
    for (int t = 1; t <= 4; t++) begin
      step();
      @(negedge clock);
`ifdef OFM_RELU_EN
      if (t == 3) chk("t6_w0", 32'(m_data), 32'h00);
`else
      if (t == 3) chk("t6_w0", 32'(m_data), 32'hF6);
`endif
      if (t == 4) chk("t6_w1", 32'(m_data), 32'h05);
    end
    wait_done(0, 0, "t6", 4);

    // Test 3: four channels, identity memory
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);
    step(); start_b4();
    wait_done(1, 0, "t3", 16);

    // Randomized rounds: random contents and random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);
      step(); start_a();
      wait_done(0, 1, "rnd_a", 4);
      step(); start_b4();
      wait_done(1, 1, "rnd_b", 16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
